shift_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the operand-2 shifter path of the RISC core.
- Decodes the data-processing IR and fetches Rm, plus Rs for register-specified shifts, through one combinational register-file read port.
- Runs a 1-bit-per-cycle shift/rotate engine and returns Q and C_out with a start/done handshake.
- Adds register-specified shift amounts (Rs[7:0], 0..255), which the single-cycle shifter cannot encode.

---
 rtl/shift_seq_ctrl_if.sv | 26 ++
 rtl/shift_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the operand-2 sequencer and its client,
// including the combinational register-file read port.
interface shift_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [31:0]       IR;
  logic              C_in;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] Q;
  logic              C_out;
  logic              busy;
  logic              done;
  logic              illegal;

  modport master (
    output start, IR, C_in, rf_data,
    input  rf_addr, Q, C_out, busy, done, illegal
  );

  modport slave (
    input  start, IR, C_in, rf_data,
    output rf_addr, Q, C_out, busy, done, illegal
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle operand-2 shifter sequencer: decodes the DP IR, reads Rm/Rs, shifts 1 bit/cycle.
// Optional macro SHIFT_CLAMP_EN clamps the loaded count so large shifts finish sooner.
module shift_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD_RM = 2'd1;
  localparam logic [1:0] RD_RS = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

`ifdef SHIFT_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  // Beyond 33 steps LSL/LSR/ASR results stop changing, and ROR repeats every 32.
  function automatic logic [AMT_W-1:0] eff_count(input logic [1:0] op_sel,
                                                 input logic [AMT_W-1:0] amt);
    logic [AMT_W-1:0] amt_m1;
    amt_m1 = amt - AMT_W'(1);
    if (CLAMP_EN && op_sel == OP_ROR && amt > AMT_W'(32))
      return {{(AMT_W-5){1'b0}}, amt_m1[4:0]} + AMT_W'(1);
    if (CLAMP_EN && op_sel != OP_ROR && amt > AMT_W'(33))
      return AMT_W'(33);
    return amt;
  endfunction

  logic [1:0]        state;
  logic [AMT_W-1:0]  cnt;
  logic [1:0]        op;
  logic              s_q;
  logic              reg_form_q;
  logic              illegal_q;
  logic [3:0]        rs_addr_q;
  logic [DATA_W-1:0] q_r;
  logic              c_out_r;
  logic              busy_r;
  logic              done_r;
  logic              illegal_r;
  logic [3:0]        rf_addr_r;

  logic              imm_form;
  logic              shift_form;
  logic [DATA_W-1:0] step_q;
  logic              step_c;
  logic              unused_ir_bits;

  assign imm_form   = (bus.IR[27:25] == 3'b001);
  assign shift_form = (bus.IR[27:25] == 3'b000) && (!bus.IR[4] || !bus.IR[7]);
  assign unused_ir_bits = ^{bus.IR[31:28], bus.IR[24:21], bus.IR[19:12]};

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    step_q = q_r;
    step_c = 1'b0;
    case (op)
      OP_LSL: begin
        step_q = {q_r[DATA_W-2:0], 1'b0};
        step_c = q_r[DATA_W-1];
      end
      OP_LSR: begin
        step_q = {1'b0, q_r[DATA_W-1:1]};
        step_c = q_r[0];
      end
      OP_ASR: begin
        step_q = {q_r[DATA_W-1], q_r[DATA_W-1:1]};
        step_c = q_r[0];
      end
      default: begin
        step_q = {q_r[0], q_r[DATA_W-1:1]};
        step_c = q_r[0];
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= OP_LSL;
      s_q        <= 1'b0;
      reg_form_q <= 1'b0;
      illegal_q  <= 1'b0;
      rs_addr_q  <= '0;
      q_r        <= '0;
      c_out_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      illegal_r  <= 1'b0;
      rf_addr_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            busy_r    <= 1'b1;
            illegal_r <= 1'b0;
            s_q       <= bus.IR[20];
            // C_out starts at the incoming carry; shifting steps overwrite it only when S=1.
            c_out_r   <= bus.C_in;
            if (imm_form) begin
              q_r       <= {{(DATA_W-8){1'b0}}, bus.IR[7:0]};
              op        <= OP_ROR;
              cnt       <= eff_count(OP_ROR, {{(AMT_W-5){1'b0}}, bus.IR[11:8], 1'b0});
              illegal_q <= 1'b0;
              state     <= SHIFT;
            end else if (shift_form) begin
              rf_addr_r  <= bus.IR[3:0];
              op         <= bus.IR[6:5];
              reg_form_q <= bus.IR[4];
              rs_addr_q  <= bus.IR[11:8];
              cnt        <= bus.IR[4] ? '0
                          : eff_count(bus.IR[6:5], {{(AMT_W-5){1'b0}}, bus.IR[11:7]});
              illegal_q  <= 1'b0;
              state      <= RD_RM;
            end else begin
              // Unsupported encodings drain through SHIFT with a zero count.
              q_r       <= '0;
              cnt       <= '0;
              illegal_q <= 1'b1;
              state     <= SHIFT;
            end
          end
        end
        RD_RM: begin
          q_r <= bus.rf_data;
          if (reg_form_q) begin
            rf_addr_r <= rs_addr_q;
            state     <= RD_RS;
          end else begin
            state <= SHIFT;
          end
        end
        RD_RS: begin
          cnt   <= eff_count(op, bus.rf_data[AMT_W-1:0]);
          state <= SHIFT;
        end
        default: begin
          if (cnt != '0) begin
            q_r <= step_q;
            if (s_q) c_out_r <= step_c;
            cnt <= cnt - AMT_W'(1);
          end else begin
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            illegal_r <= illegal_q;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.Q       = q_r;
  assign bus.C_out   = c_out_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.illegal = illegal_r;
  assign bus.rf_addr = rf_addr_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed plan cases plus random
// operations checked against an arithmetic reference model.
module tb_shift_seq_ctrl;

`ifdef SHIFT_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] regs [16];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if bus ();
  shift_seq_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  assign bus.rf_data = regs[bus.rf_addr];

  function automatic logic [31:0] ir_imm(input logic s, input logic [3:0] rot, input logic [7:0] imm8);
    return {4'hE, 3'b001, 4'b0000, s, 8'h00, rot, imm8};
  endfunction

  function automatic logic [31:0] ir_shi(input logic s, input logic [4:0] amt, input logic [1:0] op, input logic [3:0] rm);
    return {4'hE, 3'b000, 4'b1101, s, 4'h0, 4'h0, amt, op, 1'b0, rm};
  endfunction

  function automatic logic [31:0] ir_shr(input logic s, input logic [3:0] rs, input logic [1:0] op, input logic [3:0] rm);
    return {4'hE, 3'b000, 4'b1101, s, 8'h00, rs, 1'b0, op, 1'b1, rm};
  endfunction

  // Effective step count: only latency depends on it, never the result.
  function automatic int eff(input logic [1:0] op, input int amt);
    if (CLAMP_ON && op == 2'd3 && amt > 32) return ((amt - 1) % 32) + 1;
    if (CLAMP_ON && op != 2'd3 && amt > 33) return 33;
    return amt;
  endfunction

  // Barrel-shift semantics computed directly from the amount.
  function automatic void model(input logic [1:0] op, input logic [31:0] rm, input int n,
                                input logic s, input logic cin,
                                output logic [31:0] q, output logic c);
    logic sc;
    int r;
    q  = rm;
    sc = cin;
    if (n > 0) begin
      case (op)
        2'd0: begin
          if (n < 32)       begin q = rm << n; sc = rm[32-n]; end
          else if (n == 32) begin q = '0; sc = rm[0]; end
          else              begin q = '0; sc = 1'b0; end
        end
        2'd1: begin
          if (n < 32)       begin q = rm >> n; sc = rm[n-1]; end
          else if (n == 32) begin q = '0; sc = rm[31]; end
          else              begin q = '0; sc = 1'b0; end
        end
        2'd2: begin
          if (n < 32) begin q = 32'($signed(rm) >>> n); sc = rm[n-1]; end
          else        begin q = {32{rm[31]}}; sc = rm[31]; end
        end
        default: begin
          r  = n % 32;
          q  = (rm >> r) | (rm << (32 - r));
          sc = q[31];
        end
      endcase
    end
    c = s ? sc : cin;
  endfunction

  // Issue one request at the next falling edge and wait for done (bounded).
  // glitch_at >= 0 pulses start with junk inputs that many cycles after acceptance.
  task automatic run_op(input logic [31:0] ir, input logic cin, input int glitch_at,
                        output logic [31:0] q, output logic c, output logic ill,
                        output int lat, output logic busy_acc, output logic done_at_issue,
                        output logic [3:0] addr0, output logic [3:0] addr1);
    @(negedge clk);
    done_at_issue = bus.done;
    bus.IR = ir;
    bus.C_in = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_acc = bus.busy;
    addr0 = bus.rf_addr;
    addr1 = bus.rf_addr;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 600) begin
      if (lat == glitch_at) begin
        bus.start = 1'b1;
        bus.IR = $urandom;
        bus.C_in = ~cin;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) addr1 = bus.rf_addr;
    end
    bus.start = 1'b0;
    q = bus.Q;
    c = bus.C_out;
    ill = bus.illegal;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.IR = '0;
    bus.C_in = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    #12;
    total++;
    if ({bus.Q, bus.C_out, bus.busy, bus.done, bus.illegal, bus.rf_addr} !== '0)
      $display("FAIL reset_outputs: got Q=%h C=%b busy=%b done=%b ill=%b addr=%h, expected all zero",
               bus.Q, bus.C_out, bus.busy, bus.done, bus.illegal, bus.rf_addr);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_immediate();
    logic [31:0] q; logic c, ill, b, d; int lat; logic [3:0] a0, a1;
    run_op(ir_imm(1'b1, 4'd2, 8'hFF), 1'b0, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if (b !== 1'b1) $display("FAIL imm_busy: got %b expected 1", b); else passed++;
    total++; if (q !== 32'hF000000F) $display("FAIL imm_q: got %h expected f000000f", q); else passed++;
    total++; if (c !== 1'b1) $display("FAIL imm_c: got %b expected 1", c); else passed++;
    total++; if (lat != 5) $display("FAIL imm_latency: got %0d expected 5", lat); else passed++;
    total++; if (ill !== 1'b0) $display("FAIL imm_illegal: got %b expected 0", ill); else passed++;
  endtask

  task automatic test_shift_imm();
    logic [31:0] q; logic c, ill, b, d; int lat; logic [3:0] a0, a1;
    regs[1] = 32'h1E1E1E1E;
    run_op(ir_shi(1'b1, 5'd3, 2'd0, 4'd1), 1'b1, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if (q !== 32'hF0F0F0F0) $display("FAIL lsl3_q: got %h expected f0f0f0f0", q); else passed++;
    total++; if (c !== 1'b0) $display("FAIL lsl3_c: got %b expected 0", c); else passed++;
    total++; if (lat != 5) $display("FAIL lsl3_latency: got %0d expected 5", lat); else passed++;
    run_op(ir_shi(1'b1, 5'd0, 2'd0, 4'd1), 1'b1, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if (q !== 32'h1E1E1E1E) $display("FAIL lsl0_q: got %h expected 1e1e1e1e", q); else passed++;
    total++; if (c !== 1'b1) $display("FAIL lsl0_c: got %b expected 1", c); else passed++;
    total++; if (lat != 2) $display("FAIL lsl0_latency: got %0d expected 2", lat); else passed++;
  endtask

  task automatic test_shift_reg();
    logic [31:0] q; logic c, ill, b, d; int lat; logic [3:0] a0, a1;
    regs[2] = 32'h80000001;
    regs[3] = 32'h00000004;
    run_op(ir_shr(1'b1, 4'd3, 2'd1, 4'd2), 1'b1, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if (a0 !== 4'd2) $display("FAIL lsr_addr_rm: got %0d expected 2", a0); else passed++;
    total++; if (a1 !== 4'd3) $display("FAIL lsr_addr_rs: got %0d expected 3", a1); else passed++;
    total++; if (q !== 32'h08000000) $display("FAIL lsr_q: got %h expected 08000000", q); else passed++;
    total++; if (c !== 1'b0) $display("FAIL lsr_c: got %b expected 0", c); else passed++;
    total++; if (lat != 7) $display("FAIL lsr_latency: got %0d expected 7", lat); else passed++;

    regs[3] = 32'h00000028;
    regs[4] = 32'h80000000;
    run_op(ir_shr(1'b1, 4'd3, 2'd2, 4'd4), 1'b0, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if (q !== 32'hFFFFFFFF) $display("FAIL asr40_q: got %h expected ffffffff", q); else passed++;
    total++; if (c !== 1'b1) $display("FAIL asr40_c: got %b expected 1", c); else passed++;
    total++; if (lat != (CLAMP_ON ? 36 : 43))
      $display("FAIL asr40_latency: got %0d expected %0d", lat, CLAMP_ON ? 36 : 43); else passed++;

    regs[5] = 32'h000000FF;
    run_op(ir_shr(1'b1, 4'd3, 2'd3, 4'd5), 1'b0, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if (q !== 32'hFF000000) $display("FAIL ror40_q: got %h expected ff000000", q); else passed++;
    total++; if (c !== 1'b1) $display("FAIL ror40_c: got %b expected 1", c); else passed++;
    total++; if (lat != (CLAMP_ON ? 11 : 43))
      $display("FAIL ror40_latency: got %0d expected %0d", lat, CLAMP_ON ? 11 : 43); else passed++;
  endtask

  task automatic test_illegal();
    logic [31:0] q; logic c, ill, b, d; int lat; logic [3:0] a0, a1;
    logic [31:0] bad [2];
    bad[0] = {4'hE, 3'b010, 25'h1ABCDEF};
    bad[1] = {4'hE, 3'b000, 4'b0000, 1'b1, 12'h000, 4'b1001, 4'h2};
    for (int i = 0; i < 2; i++) begin
      run_op(bad[i], 1'b1, -1, q, c, ill, lat, b, d, a0, a1);
      total++; if (ill !== 1'b1) $display("FAIL illegal_flag[%0d]: got %b expected 1", i, ill); else passed++;
      total++; if (lat != 1) $display("FAIL illegal_latency[%0d]: got %0d expected 1", i, lat); else passed++;
      total++; if ({q, c} !== {32'h0, 1'b1})
        $display("FAIL illegal_result[%0d]: got Q=%h C=%b expected Q=0 C=1", i, q, c); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] q; logic c, ill, b, d; int lat; logic [3:0] a0, a1;
    regs[2] = 32'h80000001;
    regs[3] = 32'h00000004;
    run_op(ir_shr(1'b1, 4'd3, 2'd1, 4'd2), 1'b1, 4, q, c, ill, lat, b, d, a0, a1);
    total++; if ({q, c, ill} !== {32'h08000000, 1'b0, 1'b0})
      $display("FAIL ignore_start_result: got Q=%h C=%b ill=%b expected 08000000/0/0", q, c, ill); else passed++;
    total++; if (lat != 7) $display("FAIL ignore_start_latency: got %0d expected 7", lat); else passed++;
  endtask

  task automatic test_hold_and_back_to_back();
    logic [31:0] q; logic c, ill, b, d; int lat; logic [3:0] a0, a1;
    regs[6] = 32'h0000F00D;
    run_op(ir_shi(1'b1, 5'd4, 2'd1, 4'd6), 1'b0, -1, q, c, ill, lat, b, d, a0, a1);
    repeat (3) @(posedge clk);
    #1;
    total++; if ({bus.Q, bus.C_out, bus.done} !== {32'h00000F00, 1'b1, 1'b0})
      $display("FAIL hold_outputs: got Q=%h C=%b done=%b expected 00000f00/1/0",
               bus.Q, bus.C_out, bus.done); else passed++;
    run_op(ir_imm(1'b0, 4'd1, 8'h03), 1'b0, -1, q, c, ill, lat, b, d, a0, a1);
    run_op(ir_imm(1'b1, 4'd0, 8'h5A), 1'b1, -1, q, c, ill, lat, b, d, a0, a1);
    total++; if ({d, b} !== 2'b11)
      $display("FAIL b2b_accept_in_done: got done=%b busy=%b expected 1/1", d, b); else passed++;
    total++; if ({q, c, lat} !== {32'h0000005A, 1'b1, 32'd1})
      $display("FAIL b2b_result: got Q=%h C=%b lat=%0d expected 0000005a/1/1", q, c, lat); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    regs[3] = 32'h00000028;
    regs[4] = 32'h80000000;
    @(negedge clk);
    bus.IR = ir_shr(1'b1, 4'd3, 2'd2, 4'd4);
    bus.C_in = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.Q, bus.C_out, bus.busy, bus.done, bus.illegal, bus.rf_addr} !== '0)
      $display("FAIL reset_mid_outputs: got Q=%h C=%b busy=%b done=%b ill=%b addr=%h expected all zero",
               bus.Q, bus.C_out, bus.busy, bus.done, bus.illegal, bus.rf_addr);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    total++; if (dones != 0) $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] q, eq, ir, rm_val; logic c, ec, ill, b, d, s, cin; int lat, n, elat, form;
    logic [1:0] op; logic [3:0] rm, rs, rot, a0, a1; logic [4:0] amt5;
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 16; r++) regs[r] = $urandom;
      form = $urandom_range(0, 2);
      s    = 1'($urandom);
      cin  = 1'($urandom);
      op   = 2'($urandom);
      rm   = 4'($urandom);
      rs   = 4'($urandom);
      if (form == 0) begin
        rot  = 4'($urandom);
        ir   = ir_imm(s, rot, regs[0][7:0]);
        rm_val = {24'h0, regs[0][7:0]};
        op   = 2'd3;
        n    = 2 * int'(rot);
        elat = eff(op, n) + 1;
      end else if (form == 1) begin
        amt5 = 5'($urandom);
        ir   = ir_shi(s, amt5, op, rm);
        rm_val = regs[rm];
        n    = int'(amt5);
        elat = eff(op, n) + 2;
      end else begin
        if ($urandom_range(0, 1) == 0) regs[rs][7:0] = 8'($urandom_range(0, 40));
        ir   = ir_shr(s, rs, op, rm);
        rm_val = regs[rm];
        n    = int'(regs[rs][7:0]);
        elat = eff(op, n) + 3;
      end
      model(op, rm_val, n, s, cin, eq, ec);
      run_op(ir, cin, -1, q, c, ill, lat, b, d, a0, a1);
      total++;
      if ({q, c, ill} !== {eq, ec, 1'b0} || lat != elat)
        $display("FAIL random[%0d] form=%0d op=%0d n=%0d: got Q=%h C=%b ill=%b lat=%0d expected Q=%h C=%b ill=0 lat=%0d",
                 i, form, op, n, q, c, ill, lat, eq, ec, elat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_shift_imm();
    test_shift_reg();
    test_illegal();
    test_ignore_start();
    test_hold_and_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
